// File: rtl/vuop_sequencer.sv
// vuop_sequencer: accepts RVV integer arithmetic instructions and issues one micro-op per
// vector register of the LMUL group, with per-register element counts and a last flag.
module vuop_sequencer #(
  parameter int VLEN = 128,
  parameter int XLEN = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      insn_valid_i,
  output logic                      insn_ready_o,
  input  logic [31:0]               insn_i,
  input  logic [7:0]                vtype_i,
  input  logic [$clog2(VLEN):0]     vl_i,
  input  logic [XLEN-1:0]           rs1_i,
  output logic                      uop_valid_o,
  input  logic                      uop_ready_i,
  output logic [5:0]                uop_func6_o,
  output logic [2:0]                uop_func3_o,
  output logic                      uop_vm_o,
  output logic [4:0]                uop_vd_o,
  output logic [4:0]                uop_vs1_o,
  output logic [4:0]                uop_vs2_o,
  output logic [1:0]                uop_vew_o,
  output logic [XLEN-1:0]           uop_scalar_o,
  output logic [$clog2(VLEN/8):0]   uop_elems_o,
  output logic                      uop_last_o,
  output logic                      done_o,
  output logic                      illegal_o
);
  localparam int VW = $clog2(VLEN) + 1;
  localparam int EW = $clog2(VLEN / 8) + 1;
  localparam logic [2:0] OPIVV = 3'b000;
  localparam logic [2:0] OPIVI = 3'b011;
  localparam logic [2:0] OPIVX = 3'b100;
  localparam logic [5:0] F_ADD = 6'b000000;
  localparam logic [5:0] F_SUB = 6'b000010;
  localparam logic [5:0] F_MERGE = 6'b010111;
  localparam logic [5:0] F_SLL = 6'b100101;
  localparam logic [5:0] F_SRL = 6'b101000;
  localparam logic [5:0] F_SRA = 6'b101001;

  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state_q, state_d;

  logic [5:0]      func6_q;
  logic [2:0]      func3_q;
  logic            vm_q;
  logic [4:0]      vd_q, vs1_q, vs2_q;
  logic [1:0]      vsew_q;
  logic [XLEN-1:0] scalar_q;
  logic [2:0]      k_q;
  logic [VW-1:0]   rem_q;

  logic [5:0]      f6;
  logic [2:0]      f3;
  logic [4:0]      vd, vs1, vs2, amask;
  logic [1:0]      vsew;
  logic [2:0]      vlmul;
  logic [VW:0]     epr_in, vlmax;
  logic [EW-1:0]   epr;
  logic [XLEN-1:0] scalar_in;
  logic            bad, accept, fire;

  assign f6    = insn_i[31:26];
  assign vs2   = insn_i[24:20];
  assign vs1   = insn_i[19:15];
  assign f3    = insn_i[14:12];
  assign vd    = insn_i[11:7];
  assign vsew  = vtype_i[4:3];
  assign vlmul = vtype_i[2:0];

  // vlmul[2] selects fractional LMUL 1/2^(4-vlmul[1:0]); 3'b100 is reserved
  assign epr_in = (VW+1)'(VLEN / 8) >> vsew;
  assign vlmax  = vlmul[2] ? epr_in >> (3'd4 - {1'b0, vlmul[1:0]}) : epr_in << vlmul[1:0];
  assign amask  = vlmul[2] ? 5'd0 : (5'd1 << vlmul[1:0]) - 5'd1;

  assign bad = insn_i[6:0] != 7'b1010111
            || !(f3 inside {OPIVV, OPIVX, OPIVI})
            || !(f6 inside {F_ADD, F_SUB, F_MERGE, F_SLL, F_SRL, F_SRA})
            || vtype_i[7]
            || vlmul == 3'b100
            || {1'b0, vl_i} > vlmax
            || |(vd & amask)
            || |(vs2 & amask)
            || (f3 == OPIVV && |(vs1 & amask));

  // shift opcodes (func6[5] set) take the immediate unsigned
  assign scalar_in = f3 == OPIVX ? rs1_i
                   : f3 == OPIVI ? (f6[5] ? XLEN'(vs1) : {{(XLEN-5){vs1[4]}}, vs1})
                   : '0;

  assign insn_ready_o = state_q == IDLE;
  assign uop_valid_o  = state_q == ISSUE;
  assign accept       = insn_ready_o && insn_valid_i;
  assign fire         = uop_valid_o && uop_ready_i;

  assign epr          = EW'((VLEN / 8) >> vsew_q);
  assign uop_elems_o  = rem_q < VW'(epr) ? EW'(rem_q) : epr;
  assign uop_last_o   = uop_valid_o && rem_q <= VW'(epr);
  assign uop_vd_o     = vd_q + 5'(k_q);
  assign uop_vs2_o    = vs2_q + 5'(k_q);
  assign uop_vs1_o    = func3_q == OPIVV ? vs1_q + 5'(k_q) : vs1_q;
  assign uop_func6_o  = func6_q;
  assign uop_func3_o  = func3_q;
  assign uop_vm_o     = vm_q;
  assign uop_vew_o    = vsew_q;
  assign uop_scalar_o = scalar_q;

  always_comb begin
    state_d = state_q;
    state_d = (accept && !bad && vl_i != '0) ? ISSUE
            : (fire && uop_last_o) ? IDLE : state_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      illegal_o <= 1'b0;
      done_o    <= 1'b0;
      func6_q   <= '0;
      func3_q   <= '0;
      vm_q      <= 1'b0;
      vd_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vsew_q    <= '0;
      scalar_q  <= '0;
      k_q       <= '0;
      rem_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_o <= accept && bad;
      done_o    <= (accept && !bad && vl_i == '0) || (fire && uop_last_o);
      if (accept) begin
        func6_q  <= f6;
        func3_q  <= f3;
        vm_q     <= insn_i[25];
        vd_q     <= vd;
        vs1_q    <= vs1;
        vs2_q    <= vs2;
        vsew_q   <= vsew;
        scalar_q <= scalar_in;
        k_q      <= '0;
        rem_q    <= vl_i;
      end else if (fire) begin
        k_q   <= k_q + 3'd1;
        rem_q <= rem_q - VW'(uop_elems_o);
      end
    end
  end
endmodule

// File: doc/vuop_sequencer.md
VUOP_SEQUENCER -- requirements
Module: vuop_sequencer

Interface
REQ-001 SHALL have parameter VLEN, default 128, meaning bits per vector register (power of 2, >=64).
REQ-002 SHALL have parameter XLEN, default 64, meaning scalar operand width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports insn_valid_i (in, 1), insn_ready_o (out, 1) and insn_i (in, 32), forming the instruction handshake; insn_i uses the arithmetic encoding fields func6/vm/vs2/vs1/func3/vd/opcode.
REQ-006 SHALL have ports vtype_i (in, 8: vill, vma, vta, vsew[2], vlmul[3]), vl_i (in, $clog2(VLEN)+1) and rs1_i (in, XLEN), all sampled only at instruction acceptance.
REQ-007 SHALL have ports uop_valid_o (out, 1) and uop_ready_i (in, 1), forming the micro-op handshake to the VFU.
REQ-008 SHALL have micro-op payload outputs uop_func6_o (6), uop_func3_o (3), uop_vm_o (1), uop_vd_o (5), uop_vs1_o (5), uop_vs2_o (5), uop_vew_o (2), uop_scalar_o (XLEN), uop_elems_o ($clog2(VLEN/8)+1) and uop_last_o (1).
REQ-009 SHALL have outputs done_o (1, one-cycle pulse on instruction completion) and illegal_o (1, one-cycle pulse on rejected instruction).

Function
REQ-010 SHALL implement a two-state FSM, IDLE and ISSUE, with insn_ready_o = (state == IDLE).
REQ-011 In IDLE, an insn_valid_i && insn_ready_o handshake SHALL accept the instruction and latch insn_i, vtype_i, vl_i and rs1_i.
REQ-012 An accepted instruction SHALL be flagged illegal if any of the following holds: opcode != 7'b1010111; func3 not in {OPIVV, OPIVX, OPIVI}; func6 not in {ADD, SUB, MERGE, SLL, SRL, SRA}; vill = 1; vlmul = LMUL_RSVD; vl_i > VLMAX; or, for LMUL in {2,4,8}, vd, vs2 or (OPIVV only) vs1 is not a multiple of LMUL.
REQ-013 VLMAX SHALL equal (VLEN/SEW)*LMUL for integral LMUL and (VLEN/SEW)>>k for LMUL = 1/2^k, where SEW = 8<<vsew.
REQ-014 An illegal instruction SHALL pulse illegal_o in the cycle after acceptance, SHALL issue no micro-ops, SHALL NOT pulse done_o, and the FSM SHALL remain in IDLE.
REQ-015 A legal instruction with vl = 0 SHALL pulse done_o in the cycle after acceptance, SHALL issue no micro-ops, and the FSM SHALL remain in IDLE.
REQ-016 A legal instruction with vl > 0 SHALL move the FSM to ISSUE, reset the micro-op index k to 0, and set remaining elements R to vl; uop_valid_o SHALL assert in the cycle after acceptance.
REQ-017 In ISSUE, uop_valid_o SHALL be 1, and the payload SHALL be held stable until uop_ready_i is sampled high.
REQ-018 Payload SHALL be: vd+k, vs2+k, vs1+k (OPIVV; raw vs1 field otherwise), vew = vsew, latched func6/func3/vm, and uop_elems_o = min(R, VLEN/SEW).
REQ-019 uop_scalar_o SHALL be rs1_i for OPIVX; for OPIVI it SHALL be simm5 sign-extended to XLEN (ADD/SUB/MERGE) or zero-extended (SLL/SRL/SRA); it SHALL be 0 for OPIVV.
REQ-020 uop_last_o SHALL be 1 iff R <= VLEN/SEW.
REQ-021 On each micro-op handshake, k SHALL increment and R SHALL decrease by uop_elems_o; on the handshake with uop_last_o = 1 the FSM SHALL return to IDLE and pulse done_o in the next cycle, concurrently with insn_ready_o = 1.
REQ-022 Fractional LMUL SHALL produce exactly one micro-op; register numbers SHALL never wrap past 31, which REQ-012 guarantees.
REQ-023 insn_valid_i SHALL be ignored while in ISSUE.

Reset
REQ-024 On rst_ni low, the FSM SHALL go to IDLE immediately, including mid-instruction, abandoning any outstanding micro-ops without a done_o pulse.
REQ-025 Reset values SHALL be: insn_ready_o = 1, uop_valid_o = 0, uop_last_o = 0, done_o = 0, illegal_o = 0, all payload outputs = 0.

Verification
REQ-026 vadd.vv vd=8, vs2=16, vs1=24, SEW32, LMUL_4, vl=14, uop_ready_i=1 -> 4 micro-ops: (vd 8,9,10,11), elems 4,4,4,2, last only on the 4th; done_o pulses once.
REQ-027 vsll.vi simm5=5'b11111, SEW8, LMUL_1, vl=16 -> one micro-op with uop_scalar_o = 31 (zero-extended); vadd.vi with the same immediate -> uop_scalar_o = all ones (-1).
REQ-028 vadd.vv vd=3, LMUL_2 -> illegal_o pulse, no uop_valid_o, FSM stays in IDLE; likewise for vill=1, func3=OPMVV, and vl=33 at SEW32/LMUL_8 with VLMAX=32.
REQ-029 vl=0 on a legal instruction -> done_o pulses one cycle after acceptance, uop_valid_o stays 0.
REQ-030 uop_ready_i held low for 3 cycles during micro-op 2 of 4 -> payload stable during the stall and issue resumes in order; rst_ni pulse during micro-op 3 -> outputs at reset values immediately, no done_o, and the next instruction is accepted normally.
